// File: rtl/multicycle_mem_responder.sv
// Word-addressed RAM responder for the multicycle core's memory port. It inserts WAIT_CYCLES wait states
// and acknowledges each request with a one-cycle mem_ready pulse. Illegal requests complete but flag addr_error.
module multicycle_mem_responder #(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        addr_error
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] word;
  logic [31:0]       data;
  logic              is_wr;
  logic              is_err;
  logic              req_err;
  logic              do_access;

  assign req_err = (addr[1:0] != 2'b00) | (addr[31:ADDR_W+2] != '0) | (mem_read & mem_write);
  assign do_access = (state == BUSY) && (cnt == 4'd0);

  // RAM has no reset; reset moves the FSM out of BUSY so that an uncommitted write is dropped.
  always_ff @(posedge clk) begin
    if (do_access && is_wr && !is_err) ram[word] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      word       <= '0;
      data       <= 32'h0;
      is_wr      <= 1'b0;
      is_err     <= 1'b0;
      read_data  <= 32'h0;
      mem_ready  <= 1'b0;
      mem_busy   <= 1'b0;
      addr_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            word     <= addr[ADDR_W+1:2];
            data     <= write_data;
            is_wr    <= mem_write;
            is_err   <= req_err;
            cnt      <= 4'(WAIT_CYCLES);
            mem_busy <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            mem_ready  <= 1'b1;
            addr_error <= is_err;
            if (!is_wr && !is_err) read_data <= ram[word];
          end
        end
        RESP: begin
          state      <= IDLE;
          mem_ready  <= 1'b0;
          addr_error <= 1'b0;
          mem_busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
